// File: rtl/odd_parity_frame_rx.sv
// Serial frame receiver for 4-bit data with odd parity (start, d0..d3, parity, stop).
// Presents recovered data, parity and the parity-error flag on the same registered cycle.
module odd_parity_frame_rx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [3:0] data_out,
    output logic       par_out,
    output logic       pec,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [3:0]       shreg;
    logic             par_q;
    logic             sync1;
    logic             rx_s;
    logic             rx_prev;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_in;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    // Receive FSM: mid-bit sampling of each field, registered outputs loaded at the stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            par_q       <= 1'b0;
            data_out    <= '0;
            par_out     <= 1'b0;
            pec         <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s && rx_prev) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            // Start bit vanished by mid-bit: treat as a glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        if (idx == 2'd3) begin
                            state <= PARITY;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        par_q <= rx_s;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt         <= '0;
                        data_out    <= shreg;
                        par_out     <= par_q;
                        pec         <= ~(^{shreg, par_q});
                        frame_valid <= rx_s;
                        frame_err   <= ~rx_s;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odd_parity_frame_rx.sv
// Self-checking bench for odd_parity_frame_rx: directed scenarios plus randomized frames
// compared against an arithmetic reference model of frame timing and parity.
module tb_odd_parity_frame_rx;

    localparam int N = 4;

    typedef struct packed {
        int         cyc;
        logic       fv;
        logic       fe;
        logic [3:0] d;
        logic       p;
        logic       pec;
        logic       busy;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [3:0] data_out;
    logic       par_out;
    logic       pec;
    logic       frame_valid;
    logic       frame_err;
    logic       busy;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  log_q[$];
    ev_t  exp_q[$];
    bit   busy_seen;
    logic [3:0] last_d;
    logic       last_p;
    logic       last_pec;

    odd_parity_frame_rx #(.CLKS_PER_BIT(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_in       (rx_in),
        .data_out    (data_out),
        .par_out     (par_out),
        .pec         (pec),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every pulse with the outputs seen alongside it.
    always @(negedge clk) begin
        if (frame_valid || frame_err)
            log_q.push_back('{cyc, frame_valid, frame_err, data_out, par_out, pec, busy});
        if (busy) busy_seen = 1'b1;
    end

    // Reference model: line edge driven at cycle c0 reaches rx_s at c0+2 (t0); pulse at t0+N/2+6N+1.
    function automatic ev_t model(input int c0, input logic [3:0] d, input logic p, input logic s);
        ev_t e;
        int  ones;
        ones  = $countones({d, p});
        e.cyc = c0 + 2 + N / 2 + 6 * N + 1;
        e.fv  = s;
        e.fe  = ~s;
        e.d   = d;
        e.p   = p;
        e.pec = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        e.busy = 1'b0;
        return e;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (N) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic s, output int c0);
        c0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic expect_frame(input logic [3:0] d, input logic p, input logic s, input int c0);
        ev_t e;
        e = model(c0, d, p, s);
        exp_q.push_back(e);
        last_d   = e.d;
        last_p   = e.p;
        last_pec = e.pec;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_in = 1'b1;
        wait_cyc(3);
        checks++;
        if ({data_out, par_out, pec, frame_valid, frame_err, busy} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs: got d=%b p=%b pec=%b fv=%b fe=%b busy=%b, expected all 0",
                     data_out, par_out, pec, frame_valid, frame_err, busy);
        end
        rst_n = 1'b1;
        wait_cyc(N);
        last_d = 4'b0; last_p = 1'b0; last_pec = 1'b0;
    endtask

    task automatic test_good_frames();
        int c0;
        log_q.delete(); exp_q.delete();
        send_frame(4'b0101, 1'b1, 1'b1, c0); expect_frame(4'b0101, 1'b1, 1'b1, c0);
        rx_in = 1'b1; wait_cyc(N);
        send_frame(4'b0101, 1'b0, 1'b1, c0); expect_frame(4'b0101, 1'b0, 1'b1, c0);
        rx_in = 1'b1; wait_cyc(2 * N);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL good_frames_count: got %0d pulses, expected %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL good_frames[%0d]: got cyc=%0d fv=%b fe=%b d=%b p=%b pec=%b busy=%b, expected cyc=%0d fv=%b fe=%b d=%b p=%b pec=%b busy=%b",
                         i, log_q[i].cyc, log_q[i].fv, log_q[i].fe, log_q[i].d, log_q[i].p, log_q[i].pec, log_q[i].busy,
                         exp_q[i].cyc, exp_q[i].fv, exp_q[i].fe, exp_q[i].d, exp_q[i].p, exp_q[i].pec, exp_q[i].busy);
            end
        end
        checks++;
        if ({data_out, par_out, pec, frame_valid} !== {last_d, last_p, last_pec, 1'b0}) begin
            failures++;
            $display("FAIL good_frames_hold: got d=%b p=%b pec=%b fv=%b, expected d=%b p=%b pec=%b fv=0",
                     data_out, par_out, pec, frame_valid, last_d, last_p, last_pec);
        end
    endtask

    task automatic test_framing_err();
        int c0;
        log_q.delete(); exp_q.delete();
        send_frame(4'b1111, 1'b1, 1'b0, c0); expect_frame(4'b1111, 1'b1, 1'b0, c0);
        wait_cyc(3);
        checks++;
        if (log_q.size() != 1 || log_q[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL framing_err_pulse: got %0d pulses (first cyc=%0d fv=%b fe=%b d=%b pec=%b), expected 1 at cyc=%0d fe=1 d=%b pec=%b",
                     log_q.size(), (log_q.size() > 0) ? log_q[0].cyc : -1, (log_q.size() > 0) ? log_q[0].fv : 1'bx,
                     (log_q.size() > 0) ? log_q[0].fe : 1'bx, (log_q.size() > 0) ? log_q[0].d : 4'bx,
                     (log_q.size() > 0) ? log_q[0].pec : 1'bx, exp_q[0].cyc, exp_q[0].d, exp_q[0].pec);
        end
        busy_seen = 1'b0;
        wait_cyc(10 * N);
        checks++;
        if (busy_seen !== 1'b0 || log_q.size() != 1) begin
            failures++;
            $display("FAIL stuck_low: got busy_seen=%b pulses=%0d, expected busy_seen=0 pulses=1",
                     busy_seen, log_q.size());
        end
        rx_in = 1'b1;
        wait_cyc(N);
    endtask

    task automatic test_glitch();
        log_q.delete();
        busy_seen = 1'b0;
        rx_in = 1'b0;
        wait_cyc(1);
        rx_in = 1'b1;
        wait_cyc(5);
        checks++;
        if (busy_seen !== 1'b1) begin
            failures++;
            $display("FAIL glitch_start_seen: got busy_seen=%b, expected 1", busy_seen);
        end
        wait_cyc(20);
        checks++;
        if (log_q.size() != 0 || busy !== 1'b0 ||
            {data_out, par_out, pec} !== {last_d, last_p, last_pec}) begin
            failures++;
            $display("FAIL glitch_quiet: got pulses=%0d busy=%b d=%b p=%b pec=%b, expected 0 pulses busy=0 d=%b p=%b pec=%b",
                     log_q.size(), busy, data_out, par_out, pec, last_d, last_p, last_pec);
        end
    endtask

    task automatic test_reset_midframe();
        int c0;
        log_q.delete(); exp_q.delete();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx_in = 1'b1;
        wait_cyc(N / 2 + 2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_busy: got busy=%b, expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out, par_out, pec, frame_valid, frame_err, busy} !== 9'b0) begin
            failures++;
            $display("FAIL midframe_reset: got d=%b p=%b pec=%b fv=%b fe=%b busy=%b, expected all 0",
                     data_out, par_out, pec, frame_valid, frame_err, busy);
        end
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2 * N);
        checks++;
        if (log_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midframe_discard: got pulses=%0d busy=%b, expected 0 pulses busy=0",
                     log_q.size(), busy);
        end
        send_frame(4'b0011, 1'b1, 1'b1, c0); expect_frame(4'b0011, 1'b1, 1'b1, c0);
        rx_in = 1'b1; wait_cyc(2 * N);
        checks++;
        if (log_q.size() != 1 || log_q[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL post_reset_frame: got pulses=%0d (cyc=%0d fv=%b d=%b pec=%b), expected 1 at cyc=%0d fv=1 d=%b pec=%b",
                     log_q.size(), (log_q.size() > 0) ? log_q[0].cyc : -1, (log_q.size() > 0) ? log_q[0].fv : 1'bx,
                     (log_q.size() > 0) ? log_q[0].d : 4'bx, (log_q.size() > 0) ? log_q[0].pec : 1'bx,
                     exp_q[0].cyc, exp_q[0].d, exp_q[0].pec);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        log_q.delete(); exp_q.delete();
        send_frame(4'b1000, 1'b0, 1'b1, c0); expect_frame(4'b1000, 1'b0, 1'b1, c0);
        send_frame(4'b0111, 1'b0, 1'b1, c1); expect_frame(4'b0111, 1'b0, 1'b1, c1);
        rx_in = 1'b1; wait_cyc(2 * N);
        checks++;
        if (log_q.size() != 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d pulses, expected 2", log_q.size());
        end else begin
            checks++;
            if (log_q[1].cyc - log_q[0].cyc != 7 * N) begin
                failures++;
                $display("FAIL b2b_spacing: got %0d cycles, expected %0d", log_q[1].cyc - log_q[0].cyc, 7 * N);
            end
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b[%0d]: got cyc=%0d fv=%b fe=%b d=%b p=%b pec=%b, expected cyc=%0d fv=%b fe=%b d=%b p=%b pec=%b",
                         i, log_q[i].cyc, log_q[i].fv, log_q[i].fe, log_q[i].d, log_q[i].p, log_q[i].pec,
                         exp_q[i].cyc, exp_q[i].fv, exp_q[i].fe, exp_q[i].d, exp_q[i].p, exp_q[i].pec);
            end
        end
    endtask

    task automatic test_random();
        int         c0;
        logic [3:0] d;
        logic       p;
        logic       s;
        log_q.delete(); exp_q.delete();
        for (int k = 0; k < 24; k++) begin
            d = 4'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            send_frame(d, p, s, c0);
            expect_frame(d, p, s, c0);
            if (!s) begin
                rx_in = 1'b1;
                wait_cyc(N);
            end else begin
                rx_in = 1'b1;
                wait_cyc($urandom_range(0, N));
            end
        end
        rx_in = 1'b1; wait_cyc(2 * N);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got %0d pulses, expected %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random[%0d]: got cyc=%0d fv=%b fe=%b d=%b p=%b pec=%b busy=%b, expected cyc=%0d fv=%b fe=%b d=%b p=%b pec=%b busy=%b",
                         i, log_q[i].cyc, log_q[i].fv, log_q[i].fe, log_q[i].d, log_q[i].p, log_q[i].pec, log_q[i].busy,
                         exp_q[i].cyc, exp_q[i].fv, exp_q[i].fe, exp_q[i].d, exp_q[i].p, exp_q[i].pec, exp_q[i].busy);
            end
        end
        checks++;
        if ({data_out, par_out, pec} !== {last_d, last_p, last_pec}) begin
            failures++;
            $display("FAIL random_hold: got d=%b p=%b pec=%b, expected d=%b p=%b pec=%b",
                     data_out, par_out, pec, last_d, last_p, last_pec);
        end
    endtask

    initial begin
        test_reset();
        test_good_frames();
        test_framing_err();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
